spi_master: RTL
===============

Name: spi_master

Overview:
Parametrised SPI master, successor to the fixed 8-bit, mode-0, write-only SPI controller. It adds configurable word width, runtime-selectable SPI mode (CPOL/CPHA), full-duplex receive on SDO, multiple chip selects, and chip-select hold for multi-word bursts. It sits between CPU-side peripheral registers and external SPI devices (LCD, flash, ADC) and is clocked from the 100 MHz system clock.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
SPI_FREQ, 1000000, SCK frequency in Hz; HALF = CLK_FREQ/(2*SPI_FREQ), must be >= 1
DATA_WIDTH, 8, bits per transfer word (N), 1..32
NUM_CS, 1, number of chip-select lines, 1..8

Ports:
CLK_100MHz  in  1  system clock, all logic on rising edge
RST_N  in  1  asynchronous active-low reset
LOAD  in  1  start request, sampled only when BUSY=0
IN  in  DATA_WIDTH  transmit word, latched on accepted LOAD
MODE  in  2  {CPOL,CPHA}, latched on accepted LOAD
CS_SEL  in  clog2(NUM_CS) (min 1)  chip-select index, latched on accepted LOAD from IDLE only
HOLD  in  1  latched on LOAD; 1 = keep CSX asserted after this word
BUSY  out  1  high in LEAD, XFER, TAIL
DONE  out  1  one-cycle pulse at end of word
OUT  out  DATA_WIDTH  received word, valid from the DONE cycle until the next DONE
SCK  out  1  SPI clock
SDI  out  1  serial data to device (MOSI), MSB first
SDO  in  1  serial data from device (MISO)
CSX  out  NUM_CS  active-low chip selects, at most one low

Behaviour:
- Reset (async, RST_N=0): state IDLE; SCK=0, SDI=0, CSX=all 1, BUSY=0, DONE=0, OUT=0, counters and shift registers 0.
- States: IDLE, LEAD, XFER, TAIL, HELD.
- The tick counter counts 0..HALF-1 and generates a tick on HALF-1, then wraps to 0. It resets to 0 on entry to LEAD.
- IDLE, on LOAD=1: latch IN, MODE, CS_SEL, HOLD. Drive CSX[CS_SEL]=0 and SCK=CPOL. If CPHA=0, SDI=IN[N-1]. Go to LEAD.
- IDLE: SCK follows the latched CPOL of the last transfer (0 after reset).
- LEAD: HALF cycles, SCK idle, then XFER with edge counter e=0.
- XFER: each tick toggles SCK; e runs 0..2N-1. Even e = leading edge, odd e = trailing edge.
- CPHA=0: sample SDO on leading edges; on trailing edges (except the last) shift and drive the next bit on SDI.
- CPHA=1: on leading edges drive the next bit on SDI (bit N-1 first); sample SDO on trailing edges.
- After edge 2N-1, SCK is back at CPOL. Go to TAIL.
- TAIL: HALF cycles, then in one cycle: pulse DONE, OUT <= receive shift register.
  - Latched HOLD=0: CSX all 1, go to IDLE.
  - Latched HOLD=1: CSX unchanged, go to HELD.
- Latency: an accepted LOAD at cycle 0 gives DONE at cycle (2N+2)*HALF. Defaults: 900 cycles.
- HELD: BUSY=0, CSX stays low, SCK=CPOL.
  - LOAD=1: latch IN, MODE, HOLD (CS_SEL ignored, previous select kept). Set SDI as in IDLE, go to LEAD.
  - No timeout; HELD is left only via a LOAD with HOLD=0 completing, or reset.
- LOAD while BUSY=1 is ignored, with no effect on IN/MODE/HOLD latches.
- The receive shift register is N bits, MSB first. The sampled bit enters at the LSB and shifts left.
- CS_SEL >= NUM_CS: the LOAD is accepted, no CSX line is driven low, and SCK/SDI still run.
- Reset mid-transfer: all outputs return to reset values immediately, CSX released, and no DONE is generated.

Test Plan:
- SPI_FREQ=CLK_FREQ/4 (HALF=2), N=8, MODE=00, SDO looped to SDI, IN=0xA5 -> CSX[0] low for 36 cycles, 8 rising SCK edges, SDI bits 1,0,1,0,0,1,0,1, DONE at cycle 36, OUT=0xA5.
- Same setup, MODE=11, SDO driven with 0x3C aligned to falling edges -> SCK idles high, data changes on falling edges, OUT=0x3C, SDI matches 0xA5.
- N=16, MODE=01, IN=0xBEEF, loopback -> 32 SCK edges, DONE at cycle 68, OUT=0xBEEF.
- NUM_CS=4, CS_SEL=2, HOLD=1 with IN=0x12, then LOAD with HOLD=0 and IN=0x34 during HELD -> CSX=4'b1011 continuously across both words, two DONE pulses, CSX=4'b1111 after the second.
- LOAD pulsed with IN=0xFF at cycle 10 of a transfer of 0x00 -> ignored, SDI all zeros, a single DONE.
- RST_N low at cycle 15 of a transfer -> asynchronous: SCK=0, CSX all 1, BUSY=0, no DONE; a new LOAD after release transfers normally.

Source files
------------

// File: rtl/spi_master_if.sv
// SPI master bus bundle: CPU-side request/response signals plus the serial pins.
interface spi_master_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CS     = 1
);
    localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    logic                  LOAD;
    logic [DATA_WIDTH-1:0] IN;
    logic [1:0]            MODE;
    logic [CS_W-1:0]       CS_SEL;
    logic                  HOLD;
    logic                  BUSY;
    logic                  DONE;
    logic [DATA_WIDTH-1:0] OUT;
    logic                  SCK;
    logic                  SDI;
    logic                  SDO;
    logic [NUM_CS-1:0]     CSX;

    modport master (
        input  LOAD, IN, MODE, CS_SEL, HOLD, SDO,
        output BUSY, DONE, OUT, SCK, SDI, CSX
    );

    modport slave (
        output LOAD, IN, MODE, CS_SEL, HOLD, SDO,
        input  BUSY, DONE, OUT, SCK, SDI, CSX
    );
endinterface

// File: rtl/spi_master.sv
// Parametrised full-duplex SPI master: configurable word width, runtime
// CPOL/CPHA, several active-low chip selects and chip-select hold between
// words of a burst. Every output comes straight from a register.
module spi_master #(
    parameter int CLK_FREQ   = 100000000,
    parameter int SPI_FREQ   = 1000000,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CS     = 1
) (
    input  logic         CLK_100MHz,
    input  logic         RST_N,
    spi_master_if.master bus
);
    localparam int HALF  = CLK_FREQ / (2 * SPI_FREQ);
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int E_W   = $clog2(2 * DATA_WIDTH);
    localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);
    localparam logic [E_W-1:0]   E_LAST   = E_W'(2 * DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEAD = 3'd1,
        ST_XFER = 3'd2,
        ST_TAIL = 3'd3,
        ST_HELD = 3'd4
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [E_W-1:0]        e_q;
    logic [DATA_WIDTH-1:0] tx_q;
    logic [DATA_WIDTH-1:0] rx_q;
    logic                  cpha_q;
    logic                  hold_q;
    logic                  sck_q;
    logic                  sdi_q;
    logic [NUM_CS-1:0]     csx_q;
    logic                  busy_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] out_q;
    logic                  tick_s;

    // One-hot active-low select; an out-of-range index drives no line low.
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] v;
        v = {NUM_CS{1'b1}};
        for (int i = 0; i < NUM_CS; i++) begin
            if (sel == CS_W'(i)) begin
                v[i] = 1'b0;
            end else begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // Shift a received bit in at the LSB, MSB-first word order.
    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] r,
                                                       input logic                  b);
        logic [DATA_WIDTH-1:0] v;
        v    = r << 1;
        v[0] = b;
        return v;
    endfunction

    // Half-period strobe from the divider counter.
    always_comb begin
        tick_s = (cnt_q == CNT_LAST);
    end

    // Transfer sequencer: divider, edge counter, shift registers and pins.
    always_ff @(posedge CLK_100MHz or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            e_q     <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            cpha_q  <= 1'b0;
            hold_q  <= 1'b0;
            sck_q   <= 1'b0;
            sdi_q   <= 1'b0;
            csx_q   <= {NUM_CS{1'b1}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_HELD: begin
                    cnt_q <= '0;
                    if (bus.LOAD) begin
                        cpha_q  <= bus.MODE[0];
                        hold_q  <= bus.HOLD;
                        sck_q   <= bus.MODE[1];
                        busy_q  <= 1'b1;
                        state_q <= ST_LEAD;
                        // A held burst keeps the select chosen by its first word.
                        if (state_q == ST_IDLE) begin
                            csx_q <= cs_decode(bus.CS_SEL);
                        end else begin
                            csx_q <= csx_q;
                        end
                        // CPHA=0 presents the MSB before the first edge.
                        if (!bus.MODE[0]) begin
                            sdi_q <= bus.IN[DATA_WIDTH-1];
                            tx_q  <= bus.IN << 1;
                        end else begin
                            tx_q  <= bus.IN;
                        end
                    end else begin
                        state_q <= state_q;
                    end
                end
                ST_LEAD: begin
                    if (tick_s) begin
                        cnt_q   <= '0;
                        e_q     <= '0;
                        state_q <= ST_XFER;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_XFER: begin
                    if (tick_s) begin
                        cnt_q <= '0;
                        sck_q <= ~sck_q;
                        if (!e_q[0]) begin
                            // Leading edge.
                            if (cpha_q) begin
                                sdi_q <= tx_q[DATA_WIDTH-1];
                                tx_q  <= tx_q << 1;
                            end else begin
                                rx_q <= shift_in(rx_q, bus.SDO);
                            end
                        end else begin
                            // Trailing edge; CPHA=0 has nothing left to drive after the last.
                            if (cpha_q) begin
                                rx_q <= shift_in(rx_q, bus.SDO);
                            end else if (e_q != E_LAST) begin
                                sdi_q <= tx_q[DATA_WIDTH-1];
                                tx_q  <= tx_q << 1;
                            end else begin
                                tx_q <= tx_q;
                            end
                        end
                        if (e_q == E_LAST) begin
                            e_q     <= '0;
                            state_q <= ST_TAIL;
                        end else begin
                            e_q <= e_q + E_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_TAIL: begin
                    if (tick_s) begin
                        cnt_q  <= '0;
                        done_q <= 1'b1;
                        out_q  <= rx_q;
                        busy_q <= 1'b0;
                        if (hold_q) begin
                            state_q <= ST_HELD;
                        end else begin
                            csx_q   <= {NUM_CS{1'b1}};
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    csx_q   <= {NUM_CS{1'b1}};
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
    assign bus.OUT  = out_q;
    assign bus.SCK  = sck_q;
    assign bus.SDI  = sdi_q;
    assign bus.CSX  = csx_q;

endmodule
